instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle sequencer for the 4-bit-opcode core.
- Owns the PC and the instruction register, and drives the instruction-memory and data-memory handshakes.
- Presents opcode/imm_flag to the control decoder and to the ALU, and steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Sits between the instruction memory, the decoder/ALU datapath and the register file write port.

Parameters:
PC_W, 8, PC and jump/branch target width; PC wraps modulo 2^PC_W.
INSTR_W, 9, instruction width; opcode = ir[INSTR_W-1:INSTR_W-4], imm_flag = ir[INSTR_W-5].

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  leave IDLE and begin fetching at the current PC.
imem_req  output  1  instruction fetch request.
imem_addr  output  PC_W  fetch address; always equals pc.
imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle.
imem_rdata  input  INSTR_W  fetched instruction.
opcode  output  4  ir opcode field, to the decoder.
imm_flag  output  1  ir imm_flag field, to the decoder.
alu_en  output  1  ALU evaluate strobe.
branch_taken  input  1  ALU compare result; sampled in EXEC only.
target_addr  input  PC_W  jump/branch destination from the datapath.
dmem_req  output  1  data memory request.
dmem_we  output  1  store qualifier for dmem_req.
dmem_ack  input  1  data access complete.
rf_we  output  1  register file write strobe.
pc  output  PC_W  current program counter.
halted  output  1  core stopped on HALT.
retired  output  16  retired-instruction count (see Optional Feature).

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (async, any state, including mid-handshake):
  - state=IDLE, pc=0, ir=0, retired=0.
  - All strobes (imem_req, alu_en, dmem_req, dmem_we, rf_we) =0; halted=0.
- Outputs are registered or decoded from state only; no combinational path from any input to any output.
- IDLE: start=1 -> FETCH. start is ignored in every other state.
- FETCH:
  - imem_req=1 held until the edge on which imem_ack=1.
  - On that edge: ir<=imem_rdata, go DECODE.
  - An ack present in the first FETCH cycle gives a 1-cycle fetch.
- DECODE: 1 cycle; opcode 1110 (HALT) -> HALT, all others -> EXEC.
- EXEC: alu_en=1 for exactly 1 cycle, then by opcode:
  - 0000 LB, 0001 LHB, 0011 STR -> MEM.
  - 0010 JMP -> pc<=target_addr, FETCH.
  - 1010 BNE, 1011 BEQ, 1100 BLT -> pc<=branch_taken ? target_addr : pc+1, FETCH.
  - 0100 LIM, 0101 MVB, 0110 MVF, 0111 ADD, 1000 SUB, 1001 SFT, 1101 INC -> WB.
  - 1111 TBA -> pc<=pc+1, FETCH (no-op).
- MEM:
  - dmem_req=1, and dmem_we=1 only for STR; both held until dmem_ack.
  - On ack: LB/LHB -> WB; STR -> pc<=pc+1, FETCH.
- WB: rf_we=1 for exactly 1 cycle; pc<=pc+1; FETCH.
- HALT: halted=1, all strobes 0, pc frozen. Only reset exits.
- Latency with zero-wait acks:
  - ALU/LIM/MV: 4 cycles.
  - JMP/branch/TBA: 3 cycles.
  - STR: 4 cycles.
  - LB/LHB: 5 cycles.
- Boundaries:
  - pc=2^PC_W-1 plus 1 wraps to 0.
  - Acks outside FETCH/MEM are ignored.
  - branch_taken is ignored for non-branch opcodes.
  - An instruction retires on the cycle it leaves EXEC/MEM/WB toward FETCH.

Optional Feature:
- Macro: INSTR_SEQ_RETIRE_COUNT_EN.
- Defined: retired increments by 1 on each instruction retirement, wraps at 16'hFFFF->0, and is cleared by reset. HALT does not count.
- Undefined: retired is tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset, start=1, imem returns ADD (0111_0_xxxx) with ack in the same cycle -> alu_en at cycle 3, rf_we at cycle 4, pc 0->1, retired=1.
- BEQ with branch_taken=1, target_addr=8'h40 -> pc=8'h40 after EXEC. Repeat with branch_taken=0 -> pc=old+1.
- STR with dmem_ack delayed 3 cycles -> dmem_req and dmem_we held high 4 cycles, rf_we never asserted, pc+1.
- LB, then HALT (1110) -> rf_we pulse for LB, then halted=1 and pc frozen; start pulses and acks are ignored.
- pc=8'hFF, INC executed -> pc=8'h00 and the next fetch address is 8'h00.
- Assert reset while in MEM with dmem_req=1 -> same cycle: dmem_req=0, state IDLE, pc=0, retired=0.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Handshake and control bundle between the instruction sequencer and the
// instruction memory, data memory, decoder/ALU datapath and register file.
interface instr_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
);
    logic               start;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [3:0]         opcode;
    logic               imm_flag;
    logic               alu_en;
    logic               branch_taken;
    logic [PC_W-1:0]    target_addr;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;
    logic               rf_we;
    logic [PC_W-1:0]    pc;
    logic               halted;
    logic [15:0]        retired;

    modport master (
        input  start, imem_ack, imem_rdata, branch_taken, target_addr, dmem_ack,
        output imem_req, imem_addr, opcode, imm_flag, alu_en, dmem_req, dmem_we,
               rf_we, pc, halted, retired
    );

    modport slave (
        output start, imem_ack, imem_rdata, branch_taken, target_addr, dmem_ack,
        input  imem_req, imem_addr, opcode, imm_flag, alu_en, dmem_req, dmem_we,
               rf_we, pc, halted, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the 4-bit-opcode core: owns PC and IR,
// runs the fetch/data handshakes and steps FETCH -> DECODE -> EXEC -> MEM -> WB.
// Optional macro INSTR_SEQ_RETIRE_COUNT_EN builds the retired-instruction counter;
// without it the retired output is a constant zero.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start
// S_FETCH  | imem_req held until imem_ack, then IR captured
// S_DECODE | one cycle, HALT opcode diverts to S_HALT
// S_EXEC   | alu_en for one cycle, resolve jumps/branches
// S_MEM    | dmem_req (dmem_we for STR) held until dmem_ack
// S_WB     | rf_we for one cycle, pc advances
// S_HALT   | core stopped, only reset leaves
module instr_sequencer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    instr_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_LB   = 4'b0000;
    localparam logic [3:0] OP_LHB  = 4'b0001;
    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_STR  = 4'b0011;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_TBA  = 4'b1111;

    state_t             state, state_nxt;
    logic [PC_W-1:0]    pc_q, pc_nxt, pc_inc;
    logic [INSTR_W-1:0] ir_q, ir_nxt;
    logic [3:0]         op;
    logic               imem_req_q, alu_en_q, dmem_req_q, dmem_we_q, rf_we_q, halted_q;
    logic               unused_ir_bits;

    assign op             = ir_q[INSTR_W-1 -: 4];
    assign pc_inc         = pc_q + PC_W'(1);
    assign unused_ir_bits = ^ir_q[INSTR_W-6:0];

    // Next state, next PC and IR capture
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_FETCH;
            S_FETCH:  if (bus.imem_ack) begin
                          ir_nxt    = bus.imem_rdata;
                          state_nxt = S_DECODE;
                      end
            S_DECODE: state_nxt = (op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_LB, OP_LHB, OP_STR: state_nxt = S_MEM;
                    OP_JMP: begin
                        pc_nxt    = bus.target_addr;
                        state_nxt = S_FETCH;
                    end
                    OP_BNE, OP_BEQ, OP_BLT: begin
                        pc_nxt    = bus.branch_taken ? bus.target_addr : pc_inc;
                        state_nxt = S_FETCH;
                    end
                    OP_TBA: begin
                        pc_nxt    = pc_inc;
                        state_nxt = S_FETCH;
                    end
                    default:  state_nxt = S_WB;
                endcase
            end
            S_MEM: if (bus.dmem_ack) begin
                       if (op == OP_STR) begin
                           pc_nxt    = pc_inc;
                           state_nxt = S_FETCH;
                       end else begin
                           state_nxt = S_WB;
                       end
                   end
            S_WB: begin
                pc_nxt    = pc_inc;
                state_nxt = S_FETCH;
            end
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State, PC, IR and strobes registered from the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            alu_en_q   <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_q       <= pc_nxt;
            ir_q       <= ir_nxt;
            imem_req_q <= (state_nxt == S_FETCH);
            alu_en_q   <= (state_nxt == S_EXEC);
            dmem_req_q <= (state_nxt == S_MEM);
            dmem_we_q  <= (state_nxt == S_MEM) && (op == OP_STR);
            rf_we_q    <= (state_nxt == S_WB);
            halted_q   <= (state_nxt == S_HALT);
        end
    end

`ifdef INSTR_SEQ_RETIRE_COUNT_EN
    logic        retire;
    logic [15:0] retired_q;

    assign retire = ((state == S_EXEC) || (state == S_MEM) || (state == S_WB))
                    && (state_nxt == S_FETCH);

    // Count instructions as they hand control back to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       retired_q <= '0;
        else if (retire) retired_q <= retired_q + 16'd1;
    end

    assign bus.retired = retired_q;
`else
    assign bus.retired = 16'h0000;
`endif

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.opcode    = op;
    assign bus.imm_flag  = ir_q[INSTR_W-5];
    assign bus.alu_en    = alu_en_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver pushes the expected event
// stream for each instruction; the monitor pops and compares on every DUT event.
module tb_instr_sequencer;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;

    logic clk = 1'b0;
    logic reset;

    instr_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instr_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        byte tag;
        int  d0;
        int  d1;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] m_pc  = 8'h00;
    int         m_ret = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input byte tag, input int d0, input int d1);
        ev_t e;
        e.tag = tag;
        e.d0  = d0;
        e.d1  = d1;
        exp_q.push_back(e);
    endtask

    task automatic observe(input byte tag, input int d0, input int d1);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event %s got %0d/%0d, required no event", tag, d0, d1);
        end else begin
            e = exp_q.pop_front();
            if (e.tag != tag || e.d0 != d0 || e.d1 != d1) begin
                n_err++;
                $display("FAIL event_%s got %s/%0d/%0d required %s/%0d/%0d",
                         e.tag, tag, d0, d1, e.tag, e.d0, e.d1);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    function automatic int exp_retired();
`ifdef INSTR_SEQ_RETIRE_COUNT_EN
        return m_ret & 16'hFFFF;
`else
        return 0;
`endif
    endfunction

    // Monitor: turns DUT strobes into events (tag, d0, d1)
    int   fetch_cyc = 0;
    int   ireq_cnt  = 0;
    int   dreq_cnt  = 0;
    int   dwe_cnt   = 0;
    logic halted_d  = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            ireq_cnt = 0;
            dreq_cnt = 0;
            dwe_cnt  = 0;
            halted_d = 1'b0;
        end else begin
            if (bus.imem_req) ireq_cnt++;
            if (bus.dmem_req) dreq_cnt++;
            if (bus.dmem_we)  dwe_cnt++;
            if (bus.imem_req && bus.imem_ack) begin
                observe("F", int'(bus.imem_addr), ireq_cnt);
                fetch_cyc = cyc;
                ireq_cnt  = 0;
            end
            if (bus.alu_en)
                observe("E", int'({bus.opcode, bus.imm_flag}), cyc - fetch_cyc);
            if (bus.dmem_req && bus.dmem_ack) begin
                observe("M", dwe_cnt, dreq_cnt);
                dreq_cnt = 0;
                dwe_cnt  = 0;
            end
            if (bus.rf_we)
                observe("W", int'(bus.pc), cyc - fetch_cyc);
            if (bus.halted && !halted_d)
                observe("H", int'(bus.pc), cyc - fetch_cyc);
            halted_d = bus.halted;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.imem_req;
            1:       return bus.dmem_req;
            default: return bus.halted;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string name);
        for (int i = 0; i < 50; i++) begin
            if (sig(which)) return;
            step();
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_%s got timeout required assertion within 50 cycles", name);
    endtask

    // Drive one instruction through the DUT and queue its expected events.
    task automatic run_instr(input logic [8:0] instr, input logic [7:0] tgt,
                             input logic taken, input int fdly, input int ddly);
        logic [3:0] op;
        logic       is_mem;
        op     = instr[8:5];
        is_mem = (op == 4'h0) || (op == 4'h1) || (op == 4'h3);
        bus.target_addr  = tgt;
        bus.branch_taken = taken;
        push("F", int'(m_pc), fdly + 1);
        if (op == 4'hE) begin
            push("H", int'(m_pc), 2);
        end else begin
            push("E", int'(instr[8:4]), 2);
            case (op)
                4'h0, 4'h1: begin
                    push("M", 0, ddly + 1);
                    push("W", int'(m_pc), 4 + ddly);
                    m_pc = m_pc + 8'd1;
                end
                4'h3: begin
                    push("M", ddly + 1, ddly + 1);
                    m_pc = m_pc + 8'd1;
                end
                4'h2:               m_pc = tgt;
                4'hA, 4'hB, 4'hC:   m_pc = taken ? tgt : m_pc + 8'd1;
                4'hF:               m_pc = m_pc + 8'd1;
                default: begin
                    push("W", int'(m_pc), 3);
                    m_pc = m_pc + 8'd1;
                end
            endcase
            m_ret++;
        end
        wait_sig(0, "imem_req");
        repeat (fdly) step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = instr;
        step();
        bus.imem_ack   = 1'b0;
        if (is_mem) begin
            wait_sig(1, "dmem_req");
            repeat (ddly) step();
            bus.dmem_ack = 1'b1;
            step();
            bus.dmem_ack = 1'b0;
        end
        if (op == 4'hE) wait_sig(2, "halted");
        else            wait_sig(0, "imem_req");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = '0;
        bus.dmem_ack     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.target_addr  = '0;
        repeat (2) step();

        check("rst_pc",       int'(bus.pc), 0);
        check("rst_imem_req", int'(bus.imem_req), 0);
        check("rst_strobes",  int'({bus.alu_en, bus.dmem_req, bus.dmem_we, bus.rf_we}), 0);
        check("rst_halted",   int'(bus.halted), 0);
        check("rst_retired",  int'(bus.retired), 0);
        check("rst_opcode",   int'(bus.opcode), 0);

        reset = 1'b0;
        repeat (3) step();
        check("idle_no_fetch", int'(bus.imem_req), 0);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;

        run_instr(9'b0111_0_0101, 8'h00, 1'b0, 0, 0);   // ADD @00
        check("retired_after_add", int'(bus.retired), exp_retired());
        run_instr(9'b1011_1_0000, 8'h40, 1'b1, 0, 0);   // BEQ taken @01 -> 40
        run_instr(9'b1011_0_0000, 8'h10, 1'b0, 0, 0);   // BEQ not taken @40 -> 41
        run_instr(9'b0010_0_0000, 8'hFE, 1'b0, 0, 0);   // JMP @41 -> FE
        run_instr(9'b1111_0_0000, 8'h33, 1'b1, 0, 0);   // TBA @FE, branch_taken ignored
        run_instr(9'b1101_1_0001, 8'h00, 1'b0, 0, 0);   // INC @FF, pc wraps to 00
        check("pc_wrap", int'(bus.pc), 0);
        run_instr(9'b0011_0_0010, 8'h00, 1'b0, 0, 3);   // STR @00, dmem ack after 3 waits
        run_instr(9'b0000_1_0011, 8'h00, 1'b0, 0, 0);   // LB  @01
        run_instr(9'b0001_0_0100, 8'h00, 1'b0, 0, 2);   // LHB @02
        run_instr(9'b1000_1_0110, 8'h00, 1'b0, 2, 0);   // SUB @03, fetch after 2 waits
        run_instr(9'b1110_0_0000, 8'h00, 1'b0, 0, 0);   // HALT @04

        check("halt_flag", int'(bus.halted), 1);
        check("halt_pc",   int'(bus.pc), 4);
        bus.start        = 1'b1;
        bus.imem_ack     = 1'b1;
        bus.dmem_ack     = 1'b1;
        bus.branch_taken = 1'b1;
        bus.target_addr  = 8'h77;
        repeat (5) step();
        bus.start        = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.dmem_ack     = 1'b0;
        check("halt_pc_frozen",  int'(bus.pc), 4);
        check("halt_held",       int'(bus.halted), 1);
        check("halt_no_strobes", int'({bus.imem_req, bus.alu_en, bus.dmem_req, bus.rf_we}), 0);
        check("retired_at_halt", int'(bus.retired), exp_retired());

        // Reset in the middle of a data-memory handshake
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_pc  = 8'h00;
        m_ret = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_instr(9'b1111_0_0000, 8'h00, 1'b0, 0, 0);   // TBA @00 -> 01
        bus.target_addr  = 8'h00;
        bus.branch_taken = 1'b0;
        push("F", 1, 1);
        push("E", int'(5'b0011_1), 2);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 9'b0011_1_0000;                // STR @01, never acked
        step();
        bus.imem_ack   = 1'b0;
        wait_sig(1, "dmem_req_mid");
        step();
        check("mem_req_before_rst", int'({bus.dmem_req, bus.dmem_we}), 3);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_dmem_req", int'(bus.dmem_req), 0);
        check("rst_mid_dmem_we",  int'(bus.dmem_we), 0);
        check("rst_mid_pc",       int'(bus.pc), 0);
        check("rst_mid_retired",  int'(bus.retired), 0);
        step();
        reset = 1'b0;
        m_pc  = 8'h00;
        m_ret = 0;
        repeat (3) step();
        check("rst_mid_idle", int'(bus.imem_req), 0);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_instr(9'b0100_1_1010, 8'h00, 1'b0, 0, 0);   // LIM @00 after reset
        check("retired_after_rst", int'(bus.retired), exp_retired());

        repeat (2) step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
